// File: rtl/sps_layer_scheduler_pkg.sv
// Shared definitions for the SPS layer scheduler and the code fetch unit:
// descriptor layout, op-type code, state encoding and default pass length.
package sps_layer_scheduler_pkg;

  localparam int unsigned LEN_CODE       = 96;
  localparam logic        MAXPOOL_CODE   = 1'b1;
  localparam int unsigned NUM_LAYERS_DEF = 8;
  localparam int unsigned CNT_W_DEF      = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [15:0] lif_thrd;
    logic [15:0] bias_scale;
    logic [15:0] in_ch;
    logic [15:0] out_ch;
    logic [15:0] img_size;
    logic        is_pool;
  } layer_cfg_t;

  // A layer with any zero geometry field cannot be executed and is skipped.
  function automatic logic cfg_is_empty(input layer_cfg_t c);
    return (c.in_ch == '0) || (c.out_ch == '0) || (c.img_size == '0);
  endfunction

endpackage

// File: rtl/sps_layer_scheduler.sv
// Sequencer for the SPS convolution section: fetches one descriptor per layer,
// launches the conv/LIF or maxpool engine and waits for its completion.
module sps_layer_scheduler
  import sps_layer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             s_clk,
  input  logic             s_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             code_ready,
  input  logic             code_valid,
  input  logic             i_fetch_done,
  input  logic [15:0]      i_lif_thrd,
  input  logic [15:0]      i_bias_scale,
  input  logic             i_conv_or_maxpool,
  input  logic [15:0]      i_in_ch,
  input  logic [15:0]      i_out_ch,
  input  logic [15:0]      i_img_size,
  output logic [15:0]      o_lif_thrd,
  output logic [15:0]      o_bias_scale,
  output logic [15:0]      o_in_ch,
  output logic [15:0]      o_out_ch,
  output logic [15:0]      o_img_size,
  output logic             o_conv_start,
  output logic             o_pool_start,
  input  logic             i_conv_done,
  input  logic             i_pool_done,
  output logic [CNT_W-1:0] o_layer_idx,
  output logic             o_cfg_err,
  output logic             sps_part_done
);

  sched_state_e     state_q, state_d;
  layer_cfg_t       cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             conv_start_q, conv_start_d;
  logic             pool_start_q, pool_start_d;

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q      <= S_IDLE;
      cfg_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      conv_start_q <= 1'b0;
      pool_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      conv_start_q <= conv_start_d;
      pool_start_q <= pool_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    conv_start_d = 1'b0;
    pool_start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_REQ;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_REQ: begin
        // A handshake wins over table exhaustion reported in the same cycle.
        if (code_valid) begin
          cfg_d.lif_thrd   = i_lif_thrd;
          cfg_d.bias_scale = i_bias_scale;
          cfg_d.in_ch      = i_in_ch;
          cfg_d.out_ch     = i_out_ch;
          cfg_d.img_size   = i_img_size;
          cfg_d.is_pool    = i_conv_or_maxpool;
          state_d          = S_LAUNCH;
        end else if (i_fetch_done) begin
          state_d = S_DONE;
        end
      end
      S_LAUNCH: begin
        if (cfg_is_empty(cfg_q)) begin
          err_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          if (cfg_q.is_pool == MAXPOOL_CODE) pool_start_d = 1'b1;
          else                               conv_start_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if ((cfg_q.is_pool == MAXPOOL_CODE) ? i_pool_done : i_conv_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == CNT_W'(NUM_LAYERS)) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy        = (state_q != S_IDLE);
  assign code_ready    = (state_q == S_REQ);
  assign sps_part_done = (state_q == S_DONE);
  assign o_conv_start  = conv_start_q;
  assign o_pool_start  = pool_start_q;
  assign o_layer_idx   = cnt_q;
  assign o_cfg_err     = err_q;
  assign o_lif_thrd    = cfg_q.lif_thrd;
  assign o_bias_scale  = cfg_q.bias_scale;
  assign o_in_ch       = cfg_q.in_ch;
  assign o_out_ch      = cfg_q.out_ch;
  assign o_img_size    = cfg_q.img_size;

endmodule
